// File: rtl/bram_logger.sv
// Capture logger: streams valid samples into a BRAM while the FSM enables it,
// pulses run-complete on the last address and offers registered random-access readback.
module bram_logger #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_rst_cnt,
  input  logic               i_en_cnt,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_run_complete,
  output logic               o_mem_full,
  output logic [NB_ADDR-1:0] o_wr_addr
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

  logic [NB_DATA-1:0] mem_q [DEPTH];

  logic [NB_ADDR-1:0] ptr_q, ptr_d;
  logic               done_q, done_d;
  logic               run_complete_q, run_complete_d;
  logic               mem_full_q, mem_full_d;
  logic [NB_DATA-1:0] rd_data_q;
  logic               wr_en;

  // done blocks the trailing enabled cycle so address 0 is not overwritten
  assign wr_en = i_en_cnt & i_valid & ~i_rst_cnt & ~done_q;

  always_comb begin
    ptr_d          = ptr_q;
    done_d         = done_q;
    run_complete_d = 1'b0;
    mem_full_d     = mem_full_q;
    if (i_rst_cnt) begin
      ptr_d  = '0;
      done_d = 1'b0;
    end else if (wr_en) begin
      ptr_d = ptr_q + NB_ADDR'(1);
      if (ptr_q == '0) begin
        mem_full_d = 1'b0;
      end
      if (ptr_q == LAST_ADDR) begin
        done_d         = 1'b1;
        run_complete_d = 1'b1;
        mem_full_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      ptr_q          <= '0;
      done_q         <= 1'b0;
      run_complete_q <= 1'b0;
      mem_full_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      ptr_q          <= ptr_d;
      done_q         <= done_d;
      run_complete_q <= run_complete_d;
      mem_full_q     <= mem_full_d;
      rd_data_q      <= mem_q[i_rd_addr];
    end
  end

  // RAM array has no reset; read port above returns pre-write data
  always_ff @(posedge clock) begin
    if (wr_en && !i_reset) begin
      mem_q[ptr_q] <= i_data;
    end
  end

  assign o_rd_data      = rd_data_q;
  assign o_run_complete = run_complete_q;
  assign o_mem_full     = mem_full_q;
  assign o_wr_addr      = ptr_q;

endmodule

// File: tb/tb_bram_logger.sv
// Self-checking bench for bram_logger (depth 8) with a readback scoreboard.
module tb_bram_logger;

  localparam int unsigned NB_DATA = 16;
  localparam int unsigned NB_ADDR = 3;
  localparam int unsigned DEPTH   = 8;

  logic               clock = 1'b0;
  logic               i_reset, i_rst_cnt, i_en_cnt, i_valid;
  logic [NB_DATA-1:0] i_data;
  logic [NB_ADDR-1:0] i_rd_addr;
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_run_complete, o_mem_full;
  logic [NB_ADDR-1:0] o_wr_addr;

  int checks = 0;
  int errors = 0;

  logic [NB_DATA-1:0] exp_mem [DEPTH];
  logic [NB_DATA-1:0] rd_q [$];
  logic [NB_ADDR-1:0] ptr_m;
  bit                 done_m;

  always #5 clock = ~clock;

  bram_logger #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_rst_cnt      (i_rst_cnt),
    .i_en_cnt       (i_en_cnt),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_run_complete (o_run_complete),
    .o_mem_full     (o_mem_full),
    .o_wr_addr      (o_wr_addr)
  );

  // Drive one cycle, record the expected readback, update the memory model, then advance.
  task automatic step(input logic en, input logic valid, input logic rst,
                      input logic [NB_DATA-1:0] data, input logic [NB_ADDR-1:0] raddr);
    i_en_cnt  = en;
    i_valid   = valid;
    i_rst_cnt = rst;
    i_data    = data;
    i_rd_addr = raddr;
    rd_q.push_back(exp_mem[raddr]);
    if (rst) begin
      ptr_m  = '0;
      done_m = 1'b0;
    end else if (en && valid && !done_m) begin
      exp_mem[ptr_m] = data;
      if (ptr_m == NB_ADDR'(DEPTH - 1)) done_m = 1'b1;
      ptr_m = ptr_m + NB_ADDR'(1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_rst_cnt = 1'($urandom);
      i_en_cnt  = 1'($urandom);
      i_valid   = 1'($urandom);
      i_data    = NB_DATA'($urandom);
      i_rd_addr = NB_ADDR'($urandom);
      @(posedge clock);
      #1;
    end
    checks += 4;
    if (o_run_complete !== 1'b0) begin errors++; $display("FAIL reset_rc got %b exp 0", o_run_complete); end
    if (o_mem_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_mem_full); end
    if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", o_wr_addr); end
    if (o_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h exp 0000", o_rd_data); end
    i_reset   = 1'b0;
    i_rst_cnt = 1'b0;
    i_en_cnt  = 1'b0;
    i_valid   = 1'b0;
    i_rd_addr = '0;
    ptr_m     = '0;
    done_m    = 1'b0;
    rd_q.delete();
  endtask

  task automatic test_full_capture();
    logic [NB_DATA-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0010 + NB_DATA'(i), 3'd0);
      checks++;
      if (o_run_complete !== (i == 7)) begin
        errors++; $display("FAIL full_rc write %0d got %b exp %b", i, o_run_complete, (i == 7));
      end
    end
    step(1'b1, 1'b1, 1'b0, 16'hDEAD, 3'd0);
    checks += 3;
    if (o_run_complete !== 1'b0) begin errors++; $display("FAIL full_rc_drop got %b exp 0", o_run_complete); end
    if (o_mem_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", o_mem_full); end
    if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL full_ptr got %0d exp 0", o_wr_addr); end
    rd_q.delete();
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, NB_ADDR'(a));
      exp = rd_q.pop_front();
      checks += 2;
      if (o_rd_data !== exp) begin errors++; $display("FAIL full_read addr %0d got %h exp %h", a, o_rd_data, exp); end
      if (exp !== 16'h0010 + NB_DATA'(a)) begin errors++; $display("FAIL full_model addr %0d got %h exp %h", a, exp, 16'h0010 + NB_DATA'(a)); end
    end
  endtask

  task automatic test_read_during_write();
    logic [NB_DATA-1:0] exp;
    step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0010, 3'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0011, 3'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0012, 3'd0);
    rd_q.delete();
    step(1'b1, 1'b1, 1'b0, 16'hBEEF, 3'd3);
    exp = rd_q.pop_front();
    checks += 2;
    if (o_rd_data !== exp) begin errors++; $display("FAIL rdw_old got %h exp %h", o_rd_data, exp); end
    if (o_rd_data !== 16'h0013) begin errors++; $display("FAIL rdw_old_const got %h exp 0013", o_rd_data); end
    step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd3);
    exp = rd_q.pop_front();
    checks += 2;
    if (o_rd_data !== exp) begin errors++; $display("FAIL rdw_new got %h exp %h", o_rd_data, exp); end
    if (o_rd_data !== 16'hBEEF) begin errors++; $display("FAIL rdw_new_const got %h exp beef", o_rd_data); end
  endtask

  task automatic test_valid_gaps();
    logic [NB_DATA-1:0] exp;
    logic               pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b0, 16'h0020 + NB_DATA'(i), 3'd0);
      checks++;
      if (o_run_complete !== 1'b0) begin errors++; $display("FAIL gaps_rc cycle %0d got %b exp 0", i, o_run_complete); end
    end
    checks += 2;
    if (o_wr_addr !== 3'd2) begin errors++; $display("FAIL gaps_ptr got %0d exp 2", o_wr_addr); end
    if (o_mem_full !== 1'b0) begin errors++; $display("FAIL gaps_full got %b exp 0", o_mem_full); end
    rd_q.delete();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd1);
    exp = rd_q.pop_front();
    checks++;
    if (o_rd_data !== exp) begin errors++; $display("FAIL gaps_read got %h exp %h", o_rd_data, exp); end
  endtask

  task automatic test_abort();
    step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h0030 + NB_DATA'(i), 3'd0);
    checks++;
    if (o_wr_addr !== 3'd5) begin errors++; $display("FAIL abort_pre_ptr got %0d exp 5", o_wr_addr); end
    step(1'b1, 1'b1, 1'b1, 16'h0099, 3'd0);
    checks += 3;
    if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL abort_ptr got %0d exp 0", o_wr_addr); end
    if (o_mem_full !== 1'b0) begin errors++; $display("FAIL abort_full got %b exp 0", o_mem_full); end
    if (o_run_complete !== 1'b0) begin errors++; $display("FAIL abort_rc got %b exp 0", o_run_complete); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0040 + NB_DATA'(i), 3'd0);
      checks++;
      if (o_run_complete !== (i == 7)) begin
        errors++; $display("FAIL abort_rerun_rc write %0d got %b exp %b", i, o_run_complete, (i == 7));
      end
    end
    checks++;
    if (o_mem_full !== 1'b1) begin errors++; $display("FAIL abort_rerun_full got %b exp 1", o_mem_full); end
    step(1'b1, 1'b1, 1'b0, 16'h0077, 3'd0);
    checks++;
    if (o_run_complete !== 1'b0) begin errors++; $display("FAIL abort_rc_drop got %b exp 0", o_run_complete); end
  endtask

  task automatic test_rearm();
    logic [NB_DATA-1:0] exp;
    step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0);
    checks += 2;
    if (o_mem_full !== 1'b1) begin errors++; $display("FAIL rearm_hold_full got %b exp 1", o_mem_full); end
    if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL rearm_ptr0 got %0d exp 0", o_wr_addr); end
    step(1'b1, 1'b1, 1'b0, 16'h0050, 3'd0);
    checks += 2;
    if (o_mem_full !== 1'b0) begin errors++; $display("FAIL rearm_full got %b exp 0", o_mem_full); end
    if (o_wr_addr !== 3'd1) begin errors++; $display("FAIL rearm_ptr got %0d exp 1", o_wr_addr); end
    step(1'b0, 1'b1, 1'b0, 16'h0066, 3'd0);
    checks++;
    if (o_wr_addr !== 3'd1) begin errors++; $display("FAIL pause_ptr got %0d exp 1", o_wr_addr); end
    rd_q.delete();
    for (int a = 0; a < 3; a++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, NB_ADDR'(a));
      exp = rd_q.pop_front();
      checks++;
      if (o_rd_data !== exp) begin errors++; $display("FAIL rearm_read addr %0d got %h exp %h", a, o_rd_data, exp); end
    end
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rst_cnt = 1'b0;
    i_en_cnt  = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    i_rd_addr = '0;
    ptr_m     = '0;
    done_m    = 1'b0;
    test_reset();
    test_full_capture();
    test_read_during_write();
    test_valid_gaps();
    test_abort();
    test_rearm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
